writeback_stage: RTL and testbench

//  EX/WB pipeline register and writeback stage of the 3-stage (FETCH/EX/WB) MIPS-subset core; consumes the decoded EX-stage controls.

---
 rtl/writeback_stage.sv | 80 ++++++++
 tb/tb_writeback_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// EX/WB pipeline register and writeback stage: register-file write port, HI/LO
// multiply registers, GPIO output register, retired-instruction counter and forwarding selects.
module writeback_stage #(
  parameter int                DATA_W   = 32,
  parameter int                GPIO_W   = 32,
  parameter logic [GPIO_W-1:0] GPIO_RST = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_EX,
  input  logic              flush_EX,
  input  logic              regwrite_EX,
  input  logic [1:0]        regsel_EX,
  input  logic              enhilo_EX,
  input  logic              gpio_en_EX,
  input  logic [4:0]        writeaddr_EX,
  input  logic [4:0]        rs_EX,
  input  logic [4:0]        rt_EX,
  input  logic [DATA_W-1:0] alu_lo_EX,
  input  logic [DATA_W-1:0] alu_hi_EX,
  input  logic [DATA_W-1:0] gpio_data_EX,
  output logic              regwrite_WB,
  output logic [4:0]        writeaddr_WB,
  output logic [DATA_W-1:0] writedata_WB,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [CNT_W-1:0]  instret
);

  logic live;
  assign live = valid_EX & ~flush_EX;

  // mfhi/mflo read the pre-edge HI/LO; a mult in the previous cycle has already landed.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] hi,
    input logic [DATA_W-1:0] lo
  );
    logic [DATA_W-1:0] res;
    case (sel)
      2'd1:    res = hi;
      2'd2:    res = lo;
      default: res = alu;
    endcase
    return res;
  endfunction

  // EX -> WB boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_WB  <= 1'b0;
      writeaddr_WB <= 5'd0;
      writedata_WB <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      gpio_out     <= GPIO_RST;
      instret      <= '0;
    end else begin
      // $0 is never written, which also keeps forwarding off for $0.
      regwrite_WB  <= live & regwrite_EX & (writeaddr_EX != 5'd0);
      writeaddr_WB <= writeaddr_EX;
      writedata_WB <= wb_select(regsel_EX, alu_lo_EX, hi_q, lo_q);
      if (live & enhilo_EX) begin
        hi_q <= alu_hi_EX;
        lo_q <= alu_lo_EX;
      end
      if (live & gpio_en_EX) gpio_out <= gpio_data_EX[GPIO_W-1:0];
      if (live) instret <= instret + CNT_W'(1);
    end
  end

  assign fwd_a = regwrite_WB & (writeaddr_WB == rs_EX);
  assign fwd_b = regwrite_WB & (writeaddr_WB == rt_EX);

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the writeback rules.
module tb_writeback_stage;
  localparam int          DATA_W   = 32;
  localparam int          GPIO_W   = 8;
  localparam int          CNT_W    = 4;
  localparam logic [7:0]  GPIO_RST = 8'h5A;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_EX, flush_EX, regwrite_EX, enhilo_EX, gpio_en_EX;
  logic [1:0]        regsel_EX;
  logic [4:0]        writeaddr_EX, rs_EX, rt_EX;
  logic [DATA_W-1:0] alu_lo_EX, alu_hi_EX, gpio_data_EX;
  logic              regwrite_WB, fwd_a, fwd_b;
  logic [4:0]        writeaddr_WB;
  logic [DATA_W-1:0] writedata_WB, hi_q, lo_q;
  logic [GPIO_W-1:0] gpio_out;
  logic [CNT_W-1:0]  instret;

  writeback_stage #(
    .DATA_W(DATA_W), .GPIO_W(GPIO_W), .GPIO_RST(GPIO_RST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_EX(valid_EX), .flush_EX(flush_EX), .regwrite_EX(regwrite_EX),
    .regsel_EX(regsel_EX), .enhilo_EX(enhilo_EX), .gpio_en_EX(gpio_en_EX),
    .writeaddr_EX(writeaddr_EX), .rs_EX(rs_EX), .rt_EX(rt_EX),
    .alu_lo_EX(alu_lo_EX), .alu_hi_EX(alu_hi_EX), .gpio_data_EX(gpio_data_EX),
    .regwrite_WB(regwrite_WB), .writeaddr_WB(writeaddr_WB), .writedata_WB(writedata_WB),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .hi_q(hi_q), .lo_q(lo_q),
    .gpio_out(gpio_out), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: architectural state plus what WB should present.
  logic              m_rw;
  logic [4:0]        m_addr;
  logic [DATA_W-1:0] m_data, m_hi, m_lo;
  logic [GPIO_W-1:0] m_gpio;
  int                m_cnt;

  task automatic model_reset;
    m_rw = 1'b0; m_addr = 5'd0; m_data = '0;
    m_hi = '0; m_lo = '0; m_gpio = GPIO_RST; m_cnt = 0;
  endtask

  task automatic idle_inputs;
    valid_EX = 0; flush_EX = 0; regwrite_EX = 0; enhilo_EX = 0; gpio_en_EX = 0;
    regsel_EX = 0; writeaddr_EX = 0; rs_EX = 0; rt_EX = 0;
    alu_lo_EX = 0; alu_hi_EX = 0; gpio_data_EX = 0;
  endtask

  task automatic random_inputs;
    valid_EX = 1'($urandom); flush_EX = ($urandom_range(0, 3) == 0);
    regwrite_EX = 1'($urandom); enhilo_EX = 1'($urandom); gpio_en_EX = 1'($urandom);
    regsel_EX = 2'($urandom); writeaddr_EX = 5'($urandom_range(0, 7));
    rs_EX = 5'($urandom_range(0, 7)); rt_EX = 5'($urandom_range(0, 7));
    alu_lo_EX = $urandom; alu_hi_EX = $urandom; gpio_data_EX = $urandom;
  endtask

  // One clock with the current inputs; the model advances with the edge.
  task automatic tick;
    bit                retire;
    logic [DATA_W-1:0] picked;
    logic              n_rw;
    logic [4:0]        n_addr;
    logic [DATA_W-1:0] n_hi, n_lo;
    logic [GPIO_W-1:0] n_gpio;
    int                n_cnt;
    retire = valid_EX && !flush_EX;
    if (regsel_EX == 2'd1)      picked = m_hi;
    else if (regsel_EX == 2'd2) picked = m_lo;
    else                        picked = alu_lo_EX;
    n_rw   = retire && regwrite_EX && (writeaddr_EX != 0);
    n_addr = writeaddr_EX;
    n_hi   = (retire && enhilo_EX) ? alu_hi_EX : m_hi;
    n_lo   = (retire && enhilo_EX) ? alu_lo_EX : m_lo;
    n_gpio = (retire && gpio_en_EX) ? gpio_data_EX[GPIO_W-1:0] : m_gpio;
    n_cnt  = retire ? (m_cnt + 1) % (1 << CNT_W) : m_cnt;
    @(posedge clk); #1;
    m_rw = n_rw; m_addr = n_addr; m_data = picked;
    m_hi = n_hi; m_lo = n_lo; m_gpio = n_gpio; m_cnt = n_cnt;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      random_inputs();
      @(posedge clk); #1;
      n_tests++;
      if ({regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, instret} !== '0) begin
        n_fail++;
        $display("FAIL reset_state: rw=%0b addr=%0d data=%h hi=%h lo=%h cnt=%0d, required all zero",
                 regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, instret);
      end
      n_tests++;
      if (gpio_out !== GPIO_RST || fwd_a !== 1'b0 || fwd_b !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_gpio_fwd: gpio=%h fwd=%b%b, required gpio=%h fwd=00",
                 gpio_out, fwd_a, fwd_b, GPIO_RST);
      end
    end
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_add;
    idle_inputs();
    valid_EX = 1; regwrite_EX = 1; regsel_EX = 0; writeaddr_EX = 5; alu_lo_EX = 32'h1234;
    tick();
    idle_inputs();
    rs_EX = 5; rt_EX = 6;
    #1;
    n_tests++;
    if (regwrite_WB !== 1'b1 || writeaddr_WB !== 5'd5 || writedata_WB !== 32'h1234) begin
      n_fail++;
      $display("FAIL add_wb: rw=%0b addr=%0d data=%h, required rw=1 addr=5 data=00001234",
               regwrite_WB, writeaddr_WB, writedata_WB);
    end
    n_tests++;
    if (fwd_a !== 1'b1 || fwd_b !== 1'b0) begin
      n_fail++;
      $display("FAIL add_fwd: fwd_a=%0b fwd_b=%0b, required 1 0", fwd_a, fwd_b);
    end
    rs_EX = 0; rt_EX = 5;
    #1;
    n_tests++;
    if (fwd_a !== 1'b0 || fwd_b !== 1'b1) begin
      n_fail++;
      $display("FAIL add_fwd_b: fwd_a=%0b fwd_b=%0b, required 0 1", fwd_a, fwd_b);
    end
  endtask

  task automatic test_mult_mfhi;
    idle_inputs();
    valid_EX = 1; enhilo_EX = 1; alu_hi_EX = 32'hDEAD; alu_lo_EX = 32'hBEEF;
    tick();
    n_tests++;
    if (hi_q !== 32'hDEAD || lo_q !== 32'hBEEF) begin
      n_fail++;
      $display("FAIL mult_hilo: hi=%h lo=%h, required 0000dead 0000beef", hi_q, lo_q);
    end
    idle_inputs();
    valid_EX = 1; regwrite_EX = 1; regsel_EX = 1; writeaddr_EX = 3; alu_lo_EX = 32'h5555;
    tick();
    n_tests++;
    if (regwrite_WB !== 1'b1 || writeaddr_WB !== 5'd3 || writedata_WB !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL mfhi: rw=%0b addr=%0d data=%h, required 1 3 0000dead",
               regwrite_WB, writeaddr_WB, writedata_WB);
    end
    regsel_EX = 2; writeaddr_EX = 4;
    tick();
    n_tests++;
    if (writedata_WB !== 32'hBEEF || writeaddr_WB !== 5'd4) begin
      n_fail++;
      $display("FAIL mflo: addr=%0d data=%h, required 4 0000beef", writeaddr_WB, writedata_WB);
    end
    // mult and mfhi in the same cycle: the read sees the old HI
    enhilo_EX = 1; regsel_EX = 1; alu_hi_EX = 32'h1111_2222; alu_lo_EX = 32'h3333_4444;
    tick();
    n_tests++;
    if (writedata_WB !== 32'hDEAD || hi_q !== 32'h1111_2222 || lo_q !== 32'h3333_4444) begin
      n_fail++;
      $display("FAIL mult_mfhi_same: data=%h hi=%h lo=%h, required 0000dead 11112222 33334444",
               writedata_WB, hi_q, lo_q);
    end
    idle_inputs();
  endtask

  task automatic test_zero_guard;
    idle_inputs();
    valid_EX = 1; regwrite_EX = 1; writeaddr_EX = 0; alu_lo_EX = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    rs_EX = 0; rt_EX = 0;
    #1;
    n_tests++;
    if (regwrite_WB !== 1'b0 || fwd_a !== 1'b0 || fwd_b !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_guard: rw=%0b fwd=%b%b, required rw=0 fwd=00", regwrite_WB, fwd_a, fwd_b);
    end
  endtask

  task automatic test_flush;
    logic [DATA_W-1:0] hi0, lo0;
    logic [GPIO_W-1:0] g0;
    logic [CNT_W-1:0]  c0;
    hi0 = m_hi; lo0 = m_lo; g0 = m_gpio; c0 = CNT_W'(m_cnt);
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      valid_EX = (k == 0); flush_EX = (k == 0);
      regwrite_EX = 1; enhilo_EX = 1; gpio_en_EX = 1; writeaddr_EX = 7;
      alu_lo_EX = 32'hCAFE_0001; alu_hi_EX = 32'hCAFE_0002; gpio_data_EX = 32'h0000_00C3;
      tick();
      n_tests++;
      if (regwrite_WB !== 1'b0 || hi_q !== hi0 || lo_q !== lo0 || gpio_out !== g0 || instret !== c0) begin
        n_fail++;
        $display("FAIL flush_%0d: rw=%0b hi=%h lo=%h gpio=%h cnt=%0d, required 0 %h %h %h %0d",
                 k, regwrite_WB, hi_q, lo_q, gpio_out, instret, hi0, lo0, g0, c0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_gpio;
    do_reset();
    idle_inputs();
    valid_EX = 1;
    repeat (17) tick();
    n_tests++;
    if (instret !== 4'd1) begin
      n_fail++;
      $display("FAIL counter_wrap: instret=%0d, required 1", instret);
    end
    gpio_en_EX = 1; gpio_data_EX = 32'h1234_56A5;
    tick();
    n_tests++;
    if (gpio_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL gpio_write: gpio=%h, required a5", gpio_out);
    end
    gpio_en_EX = 0;
    for (int i = 0; i < 3; i++) begin
      gpio_data_EX = $urandom;
      tick();
      n_tests++;
      if (gpio_out !== 8'hA5) begin
        n_fail++;
        $display("FAIL gpio_hold_%0d: gpio=%h, required a5", i, gpio_out);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    idle_inputs();
    valid_EX = 1; enhilo_EX = 1; gpio_en_EX = 1; regwrite_EX = 1; writeaddr_EX = 9;
    alu_hi_EX = 32'h7777; alu_lo_EX = 32'h8888; gpio_data_EX = 32'h11;
    tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, instret} !== '0 || gpio_out !== GPIO_RST) begin
      n_fail++;
      $display("FAIL reset_async: rw=%0b addr=%0d data=%h hi=%h lo=%h gpio=%h cnt=%0d, required zeros gpio=%h",
               regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, gpio_out, instret, GPIO_RST);
    end
    #1 rst = 1'b1;
    idle_inputs();
    valid_EX = 1; regwrite_EX = 1; regsel_EX = 1; writeaddr_EX = 2; alu_lo_EX = 32'h99;
    tick();
    n_tests++;
    if (regwrite_WB !== 1'b1 || writedata_WB !== 32'h0 || instret !== 4'd1) begin
      n_fail++;
      $display("FAIL cold_start: rw=%0b data=%h cnt=%0d, required 1 00000000 1",
               regwrite_WB, writedata_WB, instret);
    end
    idle_inputs();
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      tick();
      n_tests++;
      if ({regwrite_WB, writeaddr_WB, writedata_WB, fwd_a, fwd_b, hi_q, lo_q, gpio_out, instret} !==
          {m_rw, m_addr, m_data, m_rw && (m_addr == rs_EX), m_rw && (m_addr == rt_EX),
           m_hi, m_lo, m_gpio, CNT_W'(m_cnt)}) begin
        n_fail++;
        $display("FAIL random_%0d: rw=%0b addr=%0d data=%h fwd=%b%b hi=%h lo=%h gpio=%h cnt=%0d, required rw=%0b addr=%0d data=%h hi=%h lo=%h gpio=%h cnt=%0d",
                 i, regwrite_WB, writeaddr_WB, writedata_WB, fwd_a, fwd_b, hi_q, lo_q, gpio_out, instret,
                 m_rw, m_addr, m_data, m_hi, m_lo, m_gpio, m_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_add();
    test_mult_mfhi();
    test_zero_guard();
    test_flush();
    test_wrap_gpio();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
